// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared constants and helper functions for the inter-stage
//             pipeline buffers of the out-of-order core.
//             - DEF_WIDTH / DEF_DEPTH : default payload width and entry count
//             - occ_width()           : bit width needed to hold 0..depth
//             - ptr_next()            : circular pointer increment with wrap
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 2;

   // Width of a counter that must represent every value 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Advance a pointer in 0..depth-1. The wrap is an explicit compare so a
   // non-power-of-two depth never visits the unused addresses.
   function automatic int unsigned ptr_next(input int unsigned ptr,
                                            input int unsigned depth);
      return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipeline_stage_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stage_regfile
//  Purpose  : DEPTH x WIDTH storage array for pipeline_stage_buffer.
//             One synchronous write port, one combinational read port.
//             No reset: contents are only meaningful where the owning control
//             logic says an entry is valid.
//  Ports    : clk        - clock, rising edge
//             wr_en_i    - write strobe
//             wr_addr_i  - write address (0..DEPTH-1)
//             wr_data_i  - write payload
//             rd_addr_i  - read address (0..DEPTH-1)
//             rd_data_o  - read payload (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_regfile #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [PW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [PW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule : pipeline_stage_regfile
`default_nettype wire

// File: rtl/pipeline_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stage_buffer
//  Purpose  : Valid/ready elastic buffer placed between two core stages.
//             DEPTH-entry circular buffer; in_ready depends on registered
//             state, flush and reset only, so no combinational ready path
//             crosses the stage. Flush empties the buffer; bubbles present
//             all-zero data.
//  Macro    : PIPELINE_STAGE_FLUSH_DELAY_EN - when defined, the effective
//             flush is stretched by one registered cycle after flush drops.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous reset, active low
//             flush     - synchronous discard of all entries
//             in_valid  / in_ready  / in_data   - upstream handshake
//             out_valid / out_ready / out_data  - downstream handshake
//             occupancy - current entry count (0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_buffer
   import pipeline_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int CW    = occ_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    occupancy
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]    count_q,  count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             flush_eff;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] rd_data;

   // ------------------------------------------------------------------------
   // Effective flush
   // ------------------------------------------------------------------------
`ifdef PIPELINE_STAGE_FLUSH_DELAY_EN
   logic flush_q;

   // Extra cycle of suppression covers wrong-path data from a 2-cycle redirect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_q <= 1'b0;
      end else begin
         flush_q <= flush;
      end
   end

   assign flush_eff = flush | flush_q;
`else
   assign flush_eff = flush;
`endif

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   // rst is folded in so upstream sees "not ready" for the whole reset window.
   assign in_ready  = (count_q < DEPTH_C) & ~flush_eff & rst;
   assign out_valid = (count_q != '0) & ~flush_eff;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? rd_data : '0;
   assign occupancy = count_q;

   // ------------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------------
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_eff) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), DEPTH));
         end
         if (pop) begin
            rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), DEPTH));
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   pipeline_stage_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_regfile (
      .clk       (clk),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (in_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

endmodule : pipeline_stage_buffer
`default_nettype wire

// File: tb/tb_pipeline_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stage_buffer
//  Purpose  : Directed self-checking bench for pipeline_stage_buffer.
//             u2 : DEPTH=2 instance (streaming, async reset)
//             u3 : DEPTH=3 instance (fill, wrap, full+out_ready, flush)
//             Honours PIPELINE_STAGE_FLUSH_DELAY_EN for the post-flush step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_buffer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;

   logic         f2, v2, r2, rdy2, ov2;
   logic [W-1:0] d2, od2;
   logic [1:0]   occ2;

   logic         f3, v3, r3, rdy3, ov3;
   logic [W-1:0] d3, od3;
   logic [1:0]   occ3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_stage_buffer #(.WIDTH(W), .DEPTH(2)) u2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (f2),
      .in_valid  (v2),
      .in_ready  (rdy2),
      .in_data   (d2),
      .out_valid (ov2),
      .out_ready (r2),
      .out_data  (od2),
      .occupancy (occ2)
   );

   pipeline_stage_buffer #(.WIDTH(W), .DEPTH(3)) u3 (
      .clk       (clk),
      .rst       (rst),
      .flush     (f3),
      .in_valid  (v3),
      .in_ready  (rdy3),
      .in_data   (d3),
      .out_valid (ov3),
      .out_ready (r3),
      .out_data  (od3),
      .occupancy (occ3)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      f2 = 0; v2 = 0; r2 = 0; d2 = '0;
      f3 = 0; v3 = 0; r3 = 0; d3 = '0;

      // ---------------- reset state ----------------
      #2;
      check("rst_out_valid", 32'(ov2),  32'd0);
      check("rst_out_data",  32'(od2),  32'd0);
      check("rst_occ",       32'(occ2), 32'd0);
      check("rst_in_ready",  32'(rdy2), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rel_in_ready2", 32'(rdy2), 32'd1);
      check("rel_in_ready3", 32'(rdy3), 32'd1);

      // ---------------- streaming, DEPTH=2 ----------------
      v2 = 1; r2 = 1; d2 = 8'h0A;
      tick();
      d2 = 8'h0B; #1;
      check("str_v1", 32'(ov2),  32'd1);
      check("str_d1", 32'(od2),  32'h0A);
      check("str_o1", 32'(occ2), 32'd1);
      tick();
      d2 = 8'h0C; #1;
      check("str_d2", 32'(od2),  32'h0B);
      check("str_o2", 32'(occ2), 32'd1);
      tick();
      v2 = 0; #1;
      check("str_d3", 32'(od2),  32'h0C);
      check("str_o3", 32'(occ2), 32'd1);
      tick();
      check("str_empty_v", 32'(ov2),  32'd0);
      check("str_empty_d", 32'(od2),  32'd0);
      check("str_empty_o", 32'(occ2), 32'd0);

      // ---------------- fill, DEPTH=3 ----------------
      r3 = 0; v3 = 1; d3 = 8'd1;
      tick(); d3 = 8'd2;
      tick(); d3 = 8'd3;
      tick(); d3 = 8'd4; #1;
      check("full_in_ready", 32'(rdy3), 32'd0);
      check("full_occ",      32'(occ3), 32'd3);
      check("full_head",     32'(od3),  32'd1);
      // full with out_ready: no pass-through, one pop only
      r3 = 1; #1;
      check("full_or_in_ready", 32'(rdy3), 32'd0);
      tick();
      check("full_or_occ",  32'(occ3), 32'd2);
      check("full_or_head", 32'(od3),  32'd2);
      check("full_or_rdy",  32'(rdy3), 32'd1);
      tick(); d3 = 8'd5; #1;
      check("wrap_d3", 32'(od3), 32'd3);
      tick(); d3 = 8'd6; #1;
      check("wrap_d4", 32'(od3), 32'd4);
      check("wrap_o4", 32'(occ3), 32'd2);
      tick(); v3 = 0; #1;
      check("wrap_d5", 32'(od3), 32'd5);
      tick();
      check("wrap_d6", 32'(od3),  32'd6);
      check("wrap_o6", 32'(occ3), 32'd1);
      tick();
      check("wrap_empty_v", 32'(ov3),  32'd0);
      check("wrap_empty_o", 32'(occ3), 32'd0);

      // ---------------- flush mid-stream, DEPTH=3 ----------------
      r3 = 0; v3 = 1; d3 = 8'd7;
      tick(); d3 = 8'd8;
      tick(); #1;
      check("pre_flush_occ", 32'(occ3), 32'd2);
      f3 = 1; d3 = 8'd9; #1;
      check("flush_out_valid", 32'(ov3),  32'd0);
      check("flush_in_ready",  32'(rdy3), 32'd0);
      check("flush_out_data",  32'(od3),  32'd0);
      tick();
      f3 = 0; v3 = 0; #1;
      check("post_flush_occ", 32'(occ3), 32'd0);
      check("post_flush_ov",  32'(ov3),  32'd0);
`ifdef PIPELINE_STAGE_FLUSH_DELAY_EN
      check("post_flush_rdy_delayed", 32'(rdy3), 32'd0);
      tick();
`endif
      check("post_flush_rdy", 32'(rdy3), 32'd1);
      check("flush_lost_occ", 32'(occ3), 32'd0);
      v3 = 1; d3 = 8'h55;
      tick();
      v3 = 0; #1;
      check("post_flush_push_d", 32'(od3),  32'h55);
      check("post_flush_push_o", 32'(occ3), 32'd1);

      // ---------------- async reset mid-operation, DEPTH=2 ----------------
      r2 = 0; v2 = 1; d2 = 8'h11;
      tick(); d2 = 8'h22;
      tick(); v2 = 0; #1;
      check("pre_arst_occ",  32'(occ2), 32'd2);
      check("pre_arst_head", 32'(od2),  32'h11);
      rst = 1'b0; #1;
      check("arst_out_valid", 32'(ov2),  32'd0);
      check("arst_out_data",  32'(od2),  32'd0);
      check("arst_occ",       32'(occ2), 32'd0);
      check("arst_in_ready",  32'(rdy2), 32'd0);
      check("arst_occ3",      32'(occ3), 32'd0);
      tick();
      rst = 1'b1; #1;
      check("arst_rel_rdy", 32'(rdy2), 32'd1);
      tick();
      check("arst_rel_occ", 32'(occ2), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pipeline_stage_buffer
`default_nettype wire
